// File: rtl/tape_status_encoder.sv
// Tape status word encoder: activity/rec flags plus BCD block counters for the overlay.
// Optional macro TAPE_STATUS_BLINK_EN blanks the record glyph on alternate BLINK_CYCLES periods.
module tape_status_encoder #(
   parameter int HOLD_CYCLES  = 10_000_000,
   parameter int BLINK_CYCLES = 4_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tape_loaded,
   input  logic        write_protect,
   input  logic        tape_play,
   input  logic        tape_rec,
   input  logic        tape_rew,
   input  logic        tape_ff,
   input  logic [9:0]  cur_idx,
   input  logic [9:0]  max_idx,
   input  logic        show,
   output logic [32:0] data,
   output logic        en,
   output logic        busy
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [3:0]      r_bit_cnt;
   logic [3:0]      r_activity;
   logic [3:0]      w_act_next;
   logic            r_rec_en;
   logic [HW-1:0]   r_hold;
   logic            r_en;
   logic            r_busy;
   logic            w_hold_load;
   logic            w_blank;
   logic            w_load;
   logic [1:0]      w_diff;
   logic [9:0]      w_idx [2];
   logic [1:0][11:0] w_digits;

   function automatic logic is_moving(input logic [3:0] a);
      return (a == 4'd1) || (a == 4'd3) || (a == 4'd4) || (a == 4'd10);
   endfunction

   function automatic logic [11:0] dd_adjust(input logic [11:0] b);
      logic [11:0] r;
      r = b;
      for (int i = 0; i < 3; i++) begin
         if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   always_comb begin
      w_act_next = 4'd2;
      if (!tape_loaded)             w_act_next = 4'd0;
      else if (tape_rew)            w_act_next = 4'd3;
      else if (tape_ff)             w_act_next = 4'd4;
      else if (tape_rec && tape_play) w_act_next = 4'd10;
      else if (tape_play)           w_act_next = 4'd1;
   end

   assign w_hold_load = is_moving(r_activity) && !is_moving(w_act_next);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_activity <= 4'd0;
         r_rec_en   <= 1'b0;
         r_hold     <= '0;
         r_en       <= 1'b0;
      end else begin
         r_activity <= w_act_next;
         r_rec_en   <= tape_loaded & ~write_protect;
         r_en       <= show | is_moving(r_activity) | (r_hold != '0);
         if (w_hold_load)         r_hold <= HW'(HOLD_CYCLES);
         else if (r_hold != '0)   r_hold <= r_hold - 1'b1;
      end
   end

`ifdef TAPE_STATUS_BLINK_EN
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_phase;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (r_activity != 4'd10) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else begin
         r_blink_cnt   <= r_blink_cnt + 1'b1;
      end
   end

   // Gate on the live code so a leftover phase never blanks a non-record glyph.
   assign w_blank = r_blink_phase && (r_activity == 4'd10);
`else
   assign w_blank = 1'b0;
`endif

   assign w_idx[0] = cur_idx;
   assign w_idx[1] = max_idx;
   assign w_load   = (r_state == S_IDLE) && (w_diff != 2'b00);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (w_diff != 2'b00) w_state_next = S_SHIFT;
         S_SHIFT:  if (r_bit_cnt == 4'd9) w_state_next = S_COMMIT;
         S_COMMIT: w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= 4'd0;
         r_busy    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= (r_state != S_IDLE);
         if (w_load)                    r_bit_cnt <= 4'd0;
         else if (r_state == S_SHIFT)   r_bit_cnt <= r_bit_cnt + 4'd1;
      end
   end

   // Engine 0 converts cur_idx, engine 1 converts max_idx; both share the FSM.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_eng
         logic [9:0]  w_clamp;
         logic [11:0] w_adj;
         logic [9:0]  r_snap;
         logic [9:0]  r_bin;
         logic [11:0] r_bcd;
         logic [11:0] r_digits;

         assign w_clamp      = (w_idx[gi] > 10'd999) ? 10'd999 : w_idx[gi];
         assign w_adj        = dd_adjust(r_bcd);
         assign w_diff[gi]   = (w_clamp != r_snap);
         assign w_digits[gi] = r_digits;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_snap   <= '0;
               r_bin    <= '0;
               r_bcd    <= '0;
               r_digits <= '0;
            end else if (w_load) begin
               r_snap <= w_clamp;
               r_bin  <= w_clamp;
               r_bcd  <= '0;
            end else if (r_state == S_SHIFT) begin
               r_bcd <= {w_adj[10:0], r_bin[9]};
               r_bin <= {r_bin[8:0], 1'b0};
            end else if (r_state == S_COMMIT) begin
               r_digits <= r_bcd;
            end
         end
      end
   endgenerate

   assign data = {4'b0000, r_rec_en, r_activity & {4{~w_blank}}, w_digits[0], w_digits[1]};
   assign en   = r_en;
   assign busy = r_busy;

endmodule

// File: tb/tb_tape_status_encoder.sv
// Directed bench for tape_status_encoder with HOLD_CYCLES = 16, BLINK_CYCLES = 8.
module tb_tape_status_encoder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        tape_loaded, write_protect, tape_play, tape_rec, tape_rew, tape_ff, show;
   logic [9:0]  cur_idx, max_idx;
   logic [32:0] data;
   logic        en, busy;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;
   logic [3:0]  exp_glyph;

   tape_status_encoder #(.HOLD_CYCLES(16), .BLINK_CYCLES(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .tape_loaded(tape_loaded), .write_protect(write_protect),
      .tape_play(tape_play), .tape_rec(tape_rec), .tape_rew(tape_rew), .tape_ff(tape_ff),
      .cur_idx(cur_idx), .max_idx(max_idx), .show(show),
      .data(data), .en(en), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      tape_loaded = 0; write_protect = 0; tape_play = 0; tape_rec = 0;
      tape_rew = 0; tape_ff = 0; show = 0;
      cur_idx = 10'd0; max_idx = 10'd0;
      repeat (3) tick();
      chk("reset_data", data, 33'h0);
      chk("reset_en", {32'b0, en}, 33'h0);
      chk("reset_busy", {32'b0, busy}, 33'h0);

      reset_n = 1'b1;
      repeat (3) tick();
      chk("idle_busy", {32'b0, busy}, 33'h0);
      chk("idle_data", data, 33'h0);
      chk("idle_en", {32'b0, en}, 33'h0);

      // 123 / 456 conversion latency
      cur_idx = 10'd123; max_idx = 10'd456;
      tick();
      chk("busy_at_E", {32'b0, busy}, 33'h0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("busy_shift", {32'b0, busy}, 33'h1);
         chk("digits_held", {9'b0, data[23:0]}, 33'h0);
      end
      tick();
      chk("busy_commit", {32'b0, busy}, 33'h1);
      chk("digits_123456", {9'b0, data[23:0]}, {9'b0, 24'h123456});
      tick();
      chk("busy_done", {32'b0, busy}, 33'h0);

      // clamp above 999
      cur_idx = 10'd1023; max_idx = 10'd1000;
      repeat (12) tick();
      chk("clamp_999", {9'b0, data[23:0]}, {9'b0, 24'h999999});
      tick();
      chk("clamp_busy_done", {32'b0, busy}, 33'h0);

      // back-to-back changes: 5, then 7 mid-conversion
      cur_idx = 10'd5;
      tick();
      repeat (3) tick();
      cur_idx = 10'd7;
      repeat (8) tick();
      chk("commit_005", {9'b0, data[23:0]}, {9'b0, 24'h005999});
      repeat (11) tick();
      chk("hold_005", {9'b0, data[23:0]}, {9'b0, 24'h005999});
      tick();
      chk("commit_007", {9'b0, data[23:0]}, {9'b0, 24'h007999});
      tick();
      chk("busy_after_007", {32'b0, busy}, 33'h0);

      // play, stop and hold timer
      tape_loaded = 1; tape_play = 1;
      tick();
      chk("play_flags", {28'b0, data[28:24]}, {28'b0, 5'h11});
      tick();
      chk("play_en", {32'b0, en}, 33'h1);
      tape_play = 0;
      tick();
      chk("stop_code", {29'b0, data[27:24]}, 33'd2);
      chk("stop_en", {32'b0, en}, 33'h1);
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk("hold_en", {32'b0, en}, 33'h1);
      end
      tick();
      chk("hold_expired", {32'b0, en}, 33'h0);
      show = 1;
      tick();
      chk("show_en", {32'b0, en}, 33'h1);
      show = 0;
      tick();
      chk("show_off", {32'b0, en}, 33'h0);

      // priority and flags
      tape_play = 1; tape_rew = 1;
      tick();
      chk("rew_code", {28'b0, data[28:24]}, {28'b0, 5'h13});
      write_protect = 1;
      tick();
      chk("wp_rec_en", {28'b0, data[28:24]}, {28'b0, 5'h03});
      tape_loaded = 0;
      tick();
      chk("unloaded", {28'b0, data[28:24]}, 33'h0);
      tape_loaded = 1; write_protect = 0; tape_rew = 0; tape_play = 0; tape_ff = 1;
      tick();
      chk("ff_code", {28'b0, data[28:24]}, {28'b0, 5'h14});

      // record glyph
      tape_ff = 0; tape_play = 1; tape_rec = 1;
      for (int k = 0; k < 24; k++) begin
         tick();
`ifdef TAPE_STATUS_BLINK_EN
         exp_glyph = (((k / 8) % 2) == 1) ? 4'd0 : 4'd10;
`else
         exp_glyph = 4'd10;
`endif
         chk("rec_glyph", {28'b0, data[28:24]}, {28'b0, 1'b1, exp_glyph});
      end

      // reset in the middle of a conversion
      tape_loaded = 0; tape_play = 0; tape_rec = 0;
      cur_idx = 10'd3;
      tick();
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      chk("midreset_data", data, 33'h0);
      chk("midreset_busy", {32'b0, busy}, 33'h0);
      chk("midreset_en", {32'b0, en}, 33'h0);
      tick();
      reset_n = 1'b1;
      tick();
      repeat (10) tick();
      chk("restart_held", {9'b0, data[23:0]}, 33'h0);
      tick();
      chk("restart_003", {9'b0, data[23:0]}, {9'b0, 24'h003999});
      tick();
      chk("restart_busy_done", {32'b0, busy}, 33'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
